// File: rtl/sqrt.sv
// Pipelined unsigned integer square root: q = floor(sqrt(radical)), remainder = radical - q*q.
// Define SQRT_OUT_REG_EN to add one output register stage (latency Q_WIDTH+1 instead of Q_WIDTH).
module sqrt #(
  parameter int RAD_WIDTH = 21,
  parameter int Q_WIDTH   = (RAD_WIDTH + 1) / 2,
  parameter int REM_WIDTH = Q_WIDTH + 1
) (
  input  logic                 clk_main,
  input  logic                 sys_rst,
  input  logic                 in_valid,
  input  logic [RAD_WIDTH-1:0] radical,
  output logic                 out_valid,
  output logic [Q_WIDTH-1:0]   q,
  output logic [REM_WIDTH-1:0] remainder
);

  localparam int RAD_PAD = 2 * Q_WIDTH;
  // Trial subtraction width: one guard bit above the shifted remainder gives the sign.
  localparam int CW      = REM_WIDTH + 3;

  typedef struct packed {
    logic [Q_WIDTH-1:0]   root;
    logic [REM_WIDTH-1:0] rem;
  } step_t;

  function automatic step_t sqrt_step(input logic [Q_WIDTH-1:0]   root_in,
                                      input logic [REM_WIDTH-1:0] rem_in,
                                      input logic [1:0]           pair);
    step_t          res;
    logic [CW-1:0]  rem_sh;
    logic [CW-1:0]  trial;
    logic [CW-1:0]  diff;
    rem_sh = {1'b0, rem_in, pair};
    trial  = {2'b00, root_in, 2'b01};
    diff   = rem_sh - trial;
    if (diff[CW-1] == 1'b0) begin
      res.root = {root_in[Q_WIDTH-2:0], 1'b1};
      res.rem  = REM_WIDTH'(diff);
    end else begin
      res.root = {root_in[Q_WIDTH-2:0], 1'b0};
      res.rem  = REM_WIDTH'(rem_sh);
    end
    return res;
  endfunction

  logic [Q_WIDTH-1:0]   root_r     [Q_WIDTH];
  logic [REM_WIDTH-1:0] rem_r      [Q_WIDTH];
  logic [RAD_PAD-1:0]   rad_r      [Q_WIDTH-1];
  logic [Q_WIDTH-1:0]   valid_r;

  logic [Q_WIDTH-1:0]   root_nxt_s [Q_WIDTH];
  logic [REM_WIDTH-1:0] rem_nxt_s  [Q_WIDTH];
  logic [RAD_PAD-1:0]   rad_in_s   [Q_WIDTH];
  logic [Q_WIDTH-1:0]   valid_in_s;

  // Route operands into each stage: stage 0 from the ports, the rest from the previous stage.
  always_comb begin
    rad_in_s[0]   = RAD_PAD'(radical);
    valid_in_s[0] = in_valid;
    for (int k = 1; k < Q_WIDTH; k++) begin
      rad_in_s[k]   = rad_r[k-1];
      valid_in_s[k] = valid_r[k-1];
    end
  end

  // One root bit per stage, taking the next two radical bits from the top.
  always_comb begin
    step_t st;
    st = sqrt_step({Q_WIDTH{1'b0}}, {REM_WIDTH{1'b0}}, rad_in_s[0][RAD_PAD-1 -: 2]);
    root_nxt_s[0] = st.root;
    rem_nxt_s[0]  = st.rem;
    for (int k = 1; k < Q_WIDTH; k++) begin
      st = sqrt_step(root_r[k-1], rem_r[k-1], rad_in_s[k][RAD_PAD-1 -: 2]);
      root_nxt_s[k] = st.root;
      rem_nxt_s[k]  = st.rem;
    end
  end

  // Pipeline registers; data only advance with a valid operand so the last stage holds its value.
  always_ff @(posedge clk_main) begin
    if (sys_rst) begin
      valid_r <= {Q_WIDTH{1'b0}};
      for (int k = 0; k < Q_WIDTH; k++) begin
        root_r[k] <= {Q_WIDTH{1'b0}};
        rem_r[k]  <= {REM_WIDTH{1'b0}};
      end
      for (int k = 0; k < Q_WIDTH - 1; k++) begin
        rad_r[k] <= {RAD_PAD{1'b0}};
      end
    end else begin
      valid_r <= valid_in_s;
      for (int k = 0; k < Q_WIDTH; k++) begin
        if (valid_in_s[k]) begin
          root_r[k] <= root_nxt_s[k];
          rem_r[k]  <= rem_nxt_s[k];
        end
      end
      for (int k = 0; k < Q_WIDTH - 1; k++) begin
        if (valid_in_s[k]) begin
          rad_r[k] <= rad_in_s[k] << 2'd2;
        end
      end
    end
  end

`ifdef SQRT_OUT_REG_EN
  logic                 out_valid_r;
  logic [Q_WIDTH-1:0]   q_r;
  logic [REM_WIDTH-1:0] rem_out_r;

  // Extra output register stage, holding results between valid outputs.
  always_ff @(posedge clk_main) begin
    if (sys_rst) begin
      out_valid_r <= 1'b0;
      q_r         <= {Q_WIDTH{1'b0}};
      rem_out_r   <= {REM_WIDTH{1'b0}};
    end else begin
      out_valid_r <= valid_r[Q_WIDTH-1];
      if (valid_r[Q_WIDTH-1]) begin
        q_r       <= root_r[Q_WIDTH-1];
        rem_out_r <= rem_r[Q_WIDTH-1];
      end
    end
  end

  assign out_valid = out_valid_r;
  assign q         = q_r;
  assign remainder = rem_out_r;
`else
  assign out_valid = valid_r[Q_WIDTH-1];
  assign q         = root_r[Q_WIDTH-1];
  assign remainder = rem_r[Q_WIDTH-1];
`endif

endmodule

// File: tb/tb_sqrt.sv
// Self-checking bench for sqrt: directed stimulus, scoreboard queue with per-item due cycle.
// Honours SQRT_OUT_REG_EN for the expected latency.
module tb_sqrt;
  localparam int RW   = 21;
  localparam int QW   = 11;
  localparam int REMW = 12;
`ifdef SQRT_OUT_REG_EN
  localparam int LAT = QW + 1;
`else
  localparam int LAT = QW;
`endif

  typedef struct {
    int unsigned     due;
    logic [QW-1:0]   q;
    logic [REMW-1:0] rem;
  } exp_t;

  logic            clk_main = 1'b0;
  logic            sys_rst;
  logic            in_valid;
  logic [RW-1:0]   radical;
  logic            out_valid;
  logic [QW-1:0]   q;
  logic [REMW-1:0] remainder;

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  int          run   = 0;
  int          max_run = 0;
  exp_t        sb[$];

  sqrt dut (
    .clk_main (clk_main),
    .sys_rst  (sys_rst),
    .in_valid (in_valid),
    .radical  (radical),
    .out_valid(out_valid),
    .q        (q),
    .remainder(remainder)
  );

  always #5 clk_main = ~clk_main;

  always @(posedge clk_main) cyc <= cyc + 1;

  function automatic int unsigned isqrt(input int unsigned x);
    int unsigned r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  task automatic send(input int unsigned x);
    int unsigned r;
    @(posedge clk_main); #1;
    r        = isqrt(x);
    radical  = RW'(x);
    in_valid = 1'b1;
    sb.push_back('{due: cyc + LAT, q: QW'(r), rem: REMW'(x - r * r)});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_main); #1;
      in_valid = 1'b0;
    end
  endtask

  // Output monitor: pop and compare when an entry is due, otherwise out_valid must be low.
  always @(negedge clk_main) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      total++;
      assert (out_valid === 1'b1) else begin
        bad++; $error("FAIL out_valid_due: got %b want 1 (cycle %0d)", out_valid, cyc);
      end
      total++;
      assert (q === e.q) else begin
        bad++; $error("FAIL q: got %0d want %0d (cycle %0d)", q, e.q, cyc);
      end
      total++;
      assert (remainder === e.rem) else begin
        bad++; $error("FAIL rem: got %0d want %0d (cycle %0d)", remainder, e.rem, cyc);
      end
    end else begin
      total++;
      assert (out_valid === 1'b0) else begin
        bad++; $error("FAIL spurious_valid: got %b want 0 (cycle %0d)", out_valid, cyc);
      end
    end
  end

  initial begin
    int n;
    sys_rst  = 1'b1;
    in_valid = 1'b1;
    radical  = RW'(5);
    repeat (3) @(posedge clk_main);
    @(negedge clk_main);
    total++;
    assert (out_valid === 1'b0) else begin bad++; $error("FAIL rst_valid: got %b want 0", out_valid); end
    total++;
    assert (q === '0) else begin bad++; $error("FAIL rst_q: got %0d want 0", q); end
    total++;
    assert (remainder === '0) else begin bad++; $error("FAIL rst_rem: got %0d want 0", remainder); end
    @(posedge clk_main); #1;
    sys_rst  = 1'b0;
    in_valid = 1'b0;

    send(0);
    idle(2);
    for (int x = 1; x <= 4; x++) send(x);
    idle(3);
    send(2097151);
    send(2096704);
    idle(LAT + 2);

    for (int x = 0; x < 4096; x++) send(x);
    idle(LAT + 3);
    total++;
    assert (max_run == 4096) else begin bad++; $error("FAIL stream_run: got %0d want 4096", max_run); end
    total++;
    assert (q === QW'(63) && remainder === REMW'(126)) else begin
      bad++; $error("FAIL hold: got q=%0d rem=%0d want q=63 rem=126", q, remainder);
    end

    for (int x = 100; x < 105; x++) send(x);
    @(posedge clk_main); #1;
    sys_rst  = 1'b1;
    in_valid = 1'b1;
    radical  = RW'(77);
    while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
    @(posedge clk_main); #1;
    sys_rst  = 1'b0;
    in_valid = 1'b0;
    send(1000);
    idle(1);

    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(posedge clk_main);
      n++;
    end
    @(negedge clk_main);
    total++;
    assert (sb.size() == 0) else begin bad++; $error("FAIL drain_timeout: got %0d pending want 0", sb.size()); end
    idle(LAT + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
